// File: rtl/modulus_16_feeder.sv
// ============================================================================
//  Module      : modulus_16_feeder
//  Description : Feeds 16-bit dividend/divisor pairs from an operand FIFO into
//                an external, flopped modulus stage with a fixed 2-edge
//                latency. Each issue carries its operands down a 2-stage
//                valid/tag pipeline. When the result returns, it is stored
//                together with its operands in a result buffer. Issue is
//                throttled so that every in-flight pair is guaranteed a slot
//                in the result buffer.
//                Optional feature macro: MODULUS_16_FEEDER_DIVZERO_EN
//                (flag b==0 pairs and return the dividend as the result).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module modulus_16_feeder #(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] mod_a,
    output logic [15:0] mod_b,
    input  logic [15:0] mod_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic        out_div_zero
);

    localparam int c_IW  = $clog2(IN_DEPTH);
    localparam int c_OW  = $clog2(OUT_DEPTH);
    localparam int c_OCW = c_OW + 2;
    localparam logic [c_IW:0]    c_IN_FULL = (c_IW + 1)'(IN_DEPTH);
    localparam logic [c_OCW-1:0] c_OCC_MAX = c_OCW'(OUT_DEPTH);

    // Operand FIFO storage and control
    logic [15:0]     r_in_a_mem [IN_DEPTH];
    logic [15:0]     r_in_b_mem [IN_DEPTH];
    logic [c_IW-1:0] r_in_wr;
    logic [c_IW-1:0] r_in_rd;
    logic [c_IW:0]   r_in_cnt;

    // Held operands and tag pipeline
    logic [15:0] r_mod_a;
    logic [15:0] r_mod_b;
    logic        r_t1_v;
    logic        r_t2_v;
    logic [15:0] r_t1_a;
    logic [15:0] r_t1_b;
    logic [15:0] r_t2_a;
    logic [15:0] r_t2_b;

    // Result buffer storage and control
    logic [15:0]     r_ob_res_mem [OUT_DEPTH];
    logic [15:0]     r_ob_a_mem   [OUT_DEPTH];
    logic [15:0]     r_ob_b_mem   [OUT_DEPTH];
    logic [c_OW-1:0] r_ob_wr;
    logic [c_OW-1:0] r_ob_rd;
    logic [c_OW:0]   r_ob_cnt;

    logic              w_in_push;
    logic              w_issue;
    logic              w_ob_push;
    logic              w_ob_pop;
    logic [c_OCW-1:0]  w_occ;
    logic [15:0]       w_head_a;
    logic [15:0]       w_head_b;
    logic [15:0]       w_cap_res;

    assign w_head_a  = r_in_a_mem[r_in_rd];
    assign w_head_b  = r_in_b_mem[r_in_rd];
    assign in_ready  = (r_in_cnt != c_IN_FULL);
    assign w_in_push = in_valid && in_ready;

    // Buffered results plus results still in the modulus stage
    assign w_occ   = c_OCW'(r_ob_cnt) + c_OCW'(r_t1_v) + c_OCW'(r_t2_v);
    assign w_issue = !rst && (r_in_cnt != '0) && (w_occ < c_OCC_MAX);

    // The modulus stage sees the FIFO head in the issue cycle, else the last issue
    assign mod_a = w_issue ? w_head_a : r_mod_a;
    assign mod_b = w_issue ? w_head_b : r_mod_b;

    assign w_ob_push = r_t2_v;
    assign out_valid = (r_ob_cnt != '0);
    assign w_ob_pop  = out_valid && out_ready;

`ifdef MODULUS_16_FEEDER_DIVZERO_EN
    logic r_t1_dz;
    logic r_t2_dz;
    logic r_ob_dz_mem [OUT_DEPTH];

    // A zero divisor returns the dividend, the modulus stage output is ignored
    assign w_cap_res    = r_t2_dz ? r_t2_a : mod_result;
    assign out_div_zero = out_valid ? r_ob_dz_mem[r_ob_rd] : 1'b0;

    // Divide-by-zero flag follows its pair through the tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_t1_dz <= 1'b0;
            r_t2_dz <= 1'b0;
        end else begin
            r_t1_dz <= (w_head_b == 16'd0);
            r_t2_dz <= r_t1_dz;
        end
    end

    // Divide-by-zero flag storage alongside each buffered result
    always_ff @(posedge clk) begin
        if (w_ob_push) begin
            r_ob_dz_mem[r_ob_wr] <= r_t2_dz;
        end
    end
`else
    assign w_cap_res    = mod_result;
    assign out_div_zero = 1'b0;
`endif

    // Output view of the buffer head, zero while the buffer is empty
    assign out_result = out_valid ? r_ob_res_mem[r_ob_rd] : 16'd0;
    assign out_a      = out_valid ? r_ob_a_mem[r_ob_rd]   : 16'd0;
    assign out_b      = out_valid ? r_ob_b_mem[r_ob_rd]   : 16'd0;

    // Operand FIFO write port
    always_ff @(posedge clk) begin
        if (w_in_push) begin
            r_in_a_mem[r_in_wr] <= in_a;
            r_in_b_mem[r_in_wr] <= in_b;
        end
    end

    // Operand FIFO pointers and occupancy; pointers wrap naturally at depth
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_wr  <= '0;
            r_in_rd  <= '0;
            r_in_cnt <= '0;
        end else begin
            if (w_in_push) r_in_wr <= r_in_wr + 1'b1;
            if (w_issue)   r_in_rd <= r_in_rd + 1'b1;
            case ({w_in_push, w_issue})
                2'b10:   r_in_cnt <= r_in_cnt + 1'b1;
                2'b01:   r_in_cnt <= r_in_cnt - 1'b1;
                default: r_in_cnt <= r_in_cnt;
            endcase
        end
    end

    // Hold registers for mod_a/mod_b and the valid/tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mod_a <= 16'd0;
            r_mod_b <= 16'd0;
            r_t1_v  <= 1'b0;
            r_t2_v  <= 1'b0;
            r_t1_a  <= 16'd0;
            r_t1_b  <= 16'd0;
            r_t2_a  <= 16'd0;
            r_t2_b  <= 16'd0;
        end else begin
            if (w_issue) begin
                r_mod_a <= w_head_a;
                r_mod_b <= w_head_b;
            end
            r_t1_v <= w_issue;
            r_t1_a <= w_head_a;
            r_t1_b <= w_head_b;
            r_t2_v <= r_t1_v;
            r_t2_a <= r_t1_a;
            r_t2_b <= r_t1_b;
        end
    end

    // Result buffer write port
    always_ff @(posedge clk) begin
        if (w_ob_push) begin
            r_ob_res_mem[r_ob_wr] <= w_cap_res;
            r_ob_a_mem[r_ob_wr]   <= r_t2_a;
            r_ob_b_mem[r_ob_wr]   <= r_t2_b;
        end
    end

    // Result buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ob_wr  <= '0;
            r_ob_rd  <= '0;
            r_ob_cnt <= '0;
        end else begin
            if (w_ob_push) r_ob_wr <= r_ob_wr + 1'b1;
            if (w_ob_pop)  r_ob_rd <= r_ob_rd + 1'b1;
            case ({w_ob_push, w_ob_pop})
                2'b10:   r_ob_cnt <= r_ob_cnt + 1'b1;
                2'b01:   r_ob_cnt <= r_ob_cnt - 1'b1;
                default: r_ob_cnt <= r_ob_cnt;
            endcase
        end
    end

endmodule

`default_nettype wire
